// File: rtl/pulse_tx_pkg.sv
// Shared types and defaults for the pulse-position frame encoder.
package pulse_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        GAP1,
        GAP2,
        BITEND,
        TRAIL,
        SCAN
    } state_t;

    localparam int DEF_NBITS     = 4;
    localparam int DEF_SHORT_GAP = 4;
    localparam int DEF_LONG_GAP  = 8;
    localparam int DEF_STEP      = 2;

    // Cycles from the first preamble pulse through the done cycle.
    function automatic int frame_len(input int nbits, input int short_gap,
                                     input int long_gap, input int step);
        return 3 * step + nbits * (short_gap + long_gap + step) + 2;
    endfunction

    function automatic int max_gap(input int long_gap, input int step);
        return (long_gap > step) ? long_gap : step;
    endfunction

endpackage

// File: rtl/pulse_tx_gap.sv
// Loadable down-counter; fire is high while the count sits at zero.
module pulse_tx_gap #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         fire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign fire = (cnt == '0);

endmodule

// File: rtl/pulse_tx.sv
// Pulse-position frame encoder driving the single-wire DATA line.
// Optional single-pulse scan stepping is enabled with `define PULSE_TX_SCAN_EN.
module pulse_tx
    import pulse_tx_pkg::*;
#(
    parameter int NBITS     = DEF_NBITS,
    parameter int SHORT_GAP = DEF_SHORT_GAP,
    parameter int LONG_GAP  = DEF_LONG_GAP,
    parameter int STEP      = DEF_STEP
) (
    input  logic             CLK_IN,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] data_in,
`ifdef PULSE_TX_SCAN_EN
    input  logic             scan_req,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             DATA_OUT
);

    localparam int GW = $clog2(max_gap(LONG_GAP, STEP));
    localparam int BW = $clog2(NBITS + 1);
    localparam logic [GW-1:0] STEP_M1  = GW'(STEP - 1);
    localparam logic [GW-1:0] SHORT_M1 = GW'(SHORT_GAP - 1);
    localparam logic [GW-1:0] LONG_M1  = GW'(LONG_GAP - 1);
    localparam logic [GW-1:0] ONE      = GW'(1);

    generate
        if (NBITS < 1 || SHORT_GAP < 2 || LONG_GAP <= SHORT_GAP || STEP < 2) begin : g_bad_params
            $fatal(1, "pulse_tx: invalid parameter combination");
        end
    endgenerate

    state_t           state, state_n;
    logic [1:0]       pre_cnt, pre_n;
    logic [BW-1:0]    bit_idx, idx_n;
    logic [NBITS-1:0] shreg, shreg_n;
    logic             data_q, data_n;
    logic             load, fire, accept;
    logic [GW-1:0]    load_val;

    pulse_tx_gap #(.W(GW)) u_gap (
        .clk      (CLK_IN),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .fire     (fire)
    );

    always_ff @(posedge CLK_IN) begin
        if (rst) begin
            state   <= IDLE;
            pre_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= 1'b0;
        end else begin
            state   <= state_n;
            pre_cnt <= pre_n;
            bit_idx <= idx_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
        end
    end

    // Each pulse is launched from the wait state that precedes it; the
    // counter is reloaded with (gap - 1) on the same edge the line goes high.
    always_comb begin
        state_n  = state;
        pre_n    = pre_cnt;
        idx_n    = bit_idx;
        shreg_n  = shreg;
        data_n   = 1'b0;
        load     = 1'b0;
        load_val = '0;
        done     = 1'b0;
        // The done cycle also accepts, so frames can run back to back.
        accept   = start && ((state == IDLE) || (state == TRAIL && fire));

        case (state)
            IDLE: begin
`ifdef PULSE_TX_SCAN_EN
                if (scan_req) begin
                    state_n  = SCAN;
                    data_n   = 1'b1;
                    load     = 1'b1;
                    load_val = ONE;
                end
`endif
            end
            PRE: begin
                if (fire) begin
                    data_n = 1'b1;
                    load   = 1'b1;
                    if (pre_cnt == 2'd2) begin
                        load_val = shreg[NBITS-1] ? LONG_M1 : SHORT_M1;
                        state_n  = GAP1;
                    end else begin
                        pre_n    = pre_cnt + 2'd1;
                        load_val = STEP_M1;
                    end
                end
            end
            GAP1: begin
                if (fire) begin
                    data_n   = 1'b1;
                    load     = 1'b1;
                    load_val = shreg[NBITS-1] ? SHORT_M1 : LONG_M1;
                    state_n  = GAP2;
                end
            end
            GAP2: begin
                if (fire) begin
                    data_n   = 1'b1;
                    load     = 1'b1;
                    load_val = STEP_M1;
                    shreg_n  = shreg << 1;
                    idx_n    = bit_idx + BW'(1);
                    state_n  = BITEND;
                end
            end
            BITEND: begin
                if (fire) begin
                    data_n = 1'b1;
                    load   = 1'b1;
                    if (bit_idx == BW'(NBITS)) begin
                        load_val = ONE;
                        state_n  = TRAIL;
                    end else begin
                        load_val = shreg[NBITS-1] ? LONG_M1 : SHORT_M1;
                        state_n  = GAP1;
                    end
                end
            end
            TRAIL: begin
                done = fire;
                if (fire) begin
                    state_n = IDLE;
                end
            end
`ifdef PULSE_TX_SCAN_EN
            SCAN: begin
                if (fire) begin
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        if (accept) begin
            state_n  = PRE;
            pre_n    = '0;
            idx_n    = '0;
            shreg_n  = data_in;
            data_n   = 1'b1;
            load     = 1'b1;
            load_val = STEP_M1;
        end
    end

    assign ready    = (state == IDLE);
    assign busy     = (state != IDLE);
    assign DATA_OUT = data_q;

endmodule

// File: tb/tb_pulse_tx.sv
// Scoreboard bench for pulse_tx: expected pulse/done cycles are queued at
// stimulus time and a negedge monitor pops them as the DUT produces them.
module tb_pulse_tx;

    localparam int NB = 4;
    localparam int SG = 4;
    localparam int LG = 8;
    localparam int ST = 2;
    localparam int TR = 3 * ST + NB * (SG + LG + ST);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic       ready, busy, done, data_out;
`ifdef PULSE_TX_SCAN_EN
    logic       scan_req = 1'b0;
`endif

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t0 = 0;
    int exp_pulse[$];
    int exp_done[$];
    bit mon_en = 1'b0;
    int hand1011[16] = '{0, 2, 4, 6, 14, 18, 20, 24, 32, 34, 42, 46, 48, 56, 60, 62};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_tx #(.NBITS(NB), .SHORT_GAP(SG), .LONG_GAP(LG), .STEP(ST)) dut (
        .CLK_IN   (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
`ifdef PULSE_TX_SCAN_EN
        .scan_req (scan_req),
`endif
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .DATA_OUT (data_out)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] d);
        start   = s;
        data_in = d;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Rising-edge schedule of one frame whose first pulse lands at cycle t.
    function automatic void pushFrame(input int t, input logic [3:0] w);
        int b;
        for (int p = 0; p < 3; p++) exp_pulse.push_back(t + p * ST);
        for (int i = 0; i < NB; i++) begin
            b = 3 * ST + i * (SG + LG + ST);
            exp_pulse.push_back(t + b);
            exp_pulse.push_back(t + b + (w[NB-1-i] ? LG : SG));
            exp_pulse.push_back(t + b + SG + LG);
        end
        exp_pulse.push_back(t + TR);
        exp_done.push_back(t + TR + 1);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (data_out) begin
                if (exp_pulse.size() == 0) checkOutput("unexpected_pulse", cyc, -1);
                else checkOutput("pulse_time", cyc, exp_pulse.pop_front());
            end else if (exp_pulse.size() != 0 && exp_pulse[0] <= cyc) begin
                checkOutput("missed_pulse", -1, exp_pulse.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) checkOutput("unexpected_done", cyc, -1);
                else checkOutput("done_time", cyc, exp_done.pop_front());
            end else if (exp_done.size() != 0 && exp_done[0] <= cyc) begin
                checkOutput("missed_done", -1, exp_done.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_data_out", data_out, 0);
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Frame 1011 against the hand-computed schedule, with a stray start at t=10.
        t0 = cyc + 1;
        foreach (hand1011[i]) exp_pulse.push_back(t0 + hand1011[i]);
        exp_done.push_back(t0 + 63);
        applyStimulus(1'b1, 4'b1011);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("busy_t0", busy, 1);
        checkOutput("ready_t0", ready, 0);
        waitUntil(t0 + 10);
        applyStimulus(1'b1, 4'b0110);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000);
        waitUntil(t0 + 63);
        checkOutput("busy_t63", busy, 1);
        checkOutput("ready_t63", ready, 0);
        @(negedge clk);
        checkOutput("busy_t64", busy, 0);
        checkOutput("ready_t64", ready, 1);
        repeat (2) @(negedge clk);

        // All-zero payload.
        t0 = cyc + 1;
        pushFrame(t0, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        @(negedge clk);
        applyStimulus(1'b0, 4'b1111);
        waitUntil(t0 + 64);
        checkOutput("idle_after_zero", ready, 1);
        repeat (3) @(negedge clk);

        // start held high: contiguous frames, payload taken only at acceptance.
        t0 = cyc + 1;
        pushFrame(t0, 4'hA);
        pushFrame(t0 + 64, 4'h5);
        applyStimulus(1'b1, 4'hA);
        @(negedge clk);
        applyStimulus(1'b1, 4'h5);
        waitUntil(t0 + 64);
        checkOutput("b2b_busy", busy, 1);
        checkOutput("b2b_ready", ready, 0);
        applyStimulus(1'b0, 4'hF);
        waitUntil(t0 + 128);
        checkOutput("b2b_idle", ready, 1);
        repeat (2) @(negedge clk);

        // Reset in the middle of a frame, then a clean frame.
        t0 = cyc + 1;
        pushFrame(t0, 4'b1100);
        applyStimulus(1'b1, 4'b1100);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000);
        waitUntil(t0 + 25);
        rst = 1'b1;
        exp_pulse.delete();
        exp_done.delete();
        @(negedge clk);
        checkOutput("midrst_data_out", data_out, 0);
        checkOutput("midrst_ready", ready, 1);
        checkOutput("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        t0 = cyc + 1;
        pushFrame(t0, 4'b1011);
        applyStimulus(1'b1, 4'b1011);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000);
        waitUntil(t0 + 64);
        checkOutput("post_rst_idle", ready, 1);

`ifdef PULSE_TX_SCAN_EN
        // Two scan pulses, then start beating a simultaneous scan_req.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            t0 = cyc + 1;
            exp_pulse.push_back(t0);
            scan_req = 1'b1;
            @(negedge clk);
            scan_req = 1'b0;
            checkOutput("scan_busy0", busy, 1);
            @(negedge clk);
            checkOutput("scan_busy1", busy, 1);
            @(negedge clk);
            checkOutput("scan_idle", ready, 1);
        end
        t0 = cyc + 1;
        pushFrame(t0, 4'b0101);
        scan_req = 1'b1;
        applyStimulus(1'b1, 4'b0101);
        @(negedge clk);
        scan_req = 1'b0;
        applyStimulus(1'b0, 4'b0000);
        waitUntil(t0 + 64);
`endif

        for (int i = 0; i < 200 && (exp_pulse.size() != 0 || exp_done.size() != 0); i++)
            @(negedge clk);
        checkOutput("pulse_queue_drained", exp_pulse.size(), 0);
        checkOutput("done_queue_drained", exp_done.size(), 0);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
